// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds:
//   SEG_W, BCD_W    - segment and BCD digit widths
//   SEG_A .. SEG_G  - bit index of each segment inside a segment word
//   SEG_0 .. SEG_9  - lit-segment patterns for decimal digits
//   SEG_ALL         - all seven segments lit (used for non-BCD codes)
//   phase_e         - BLANK/ON phase within one digit slot
package seg_scan_ctrl_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Bit order is g f e d c b a (MSB..LSB).
    localparam logic [SEG_W-1:0] SEG_0   = 7'b011_1111;  // a-f
    localparam logic [SEG_W-1:0] SEG_1   = 7'b000_0110;  // b,c
    localparam logic [SEG_W-1:0] SEG_2   = 7'b101_1011;  // a,b,d,e,g
    localparam logic [SEG_W-1:0] SEG_3   = 7'b100_1111;  // a,b,c,d,g
    localparam logic [SEG_W-1:0] SEG_4   = 7'b110_0110;  // b,c,f,g
    localparam logic [SEG_W-1:0] SEG_5   = 7'b110_1101;  // a,c,d,f,g
    localparam logic [SEG_W-1:0] SEG_6   = 7'b111_1101;  // a,c-g
    localparam logic [SEG_W-1:0] SEG_7   = 7'b000_0111;  // a,b,c
    localparam logic [SEG_W-1:0] SEG_8   = 7'b111_1111;  // all
    localparam logic [SEG_W-1:0] SEG_9   = 7'b110_1111;  // a-d,f,g
    localparam logic [SEG_W-1:0] SEG_ALL = 7'b111_1111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to 7-segment pattern decoder.
// Ports:
//   bcd_i [BCD_W] - BCD digit; codes 0xA-0xF light every segment
//   seg_o [SEG_W] - active-high segment pattern, [0]=a .. [6]=g
module bcd_to_seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_ALL;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_ALL;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// 7-segment display with per-slot blanking, leading-zero blanking and
// frame-synchronous update of the displayed word.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   load, bcd_in      - one-cycle strobe capturing a packed BCD word
//   lzb_en            - leading-zero blanking enable (level)
//   digit_en          - registered one-hot digit select
//   segment           - registered segment drive, [0]=a .. [6]=g
//   frame_done        - registered one-cycle pulse per frame
//
// Slot phase (decoded from cnt_q):
//   phase    | meaning
//   PH_BLANK | cnt_q < BLANK, all digits off to avoid ghosting
//   PH_ON    | current digit driven unless leading-zero blanked
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        lzb_en,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic [SEG_W-1:0]            segment,
    output logic                        frame_done
);

    localparam int WORD_W = BCD_W * NUM_DIGITS;
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_W-1:0]     disp_q, disp_d;
    logic [WORD_W-1:0]     pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [SEG_W-1:0]      segment_q, segment_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_end;
    phase_e                phase;
    logic [BCD_W-1:0]      cur_bcd;
    logic [NUM_DIGITS-1:0] digit_hot;
    logic                  zero_run;
    logic                  lz_blank;
    logic                  show;
    logic [SEG_W-1:0]      seg_dec;

    bcd_to_seg u_dec (
        .bcd_i (cur_bcd),
        .seg_o (seg_dec)
    );

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // A load on the boundary cycle bypasses pend so it is not lost
        // when pend_v clears on that same edge.
        pend_d   = load ? bcd_in : pend_q;
        pend_v_d = pend_v_q | load;
        disp_d   = disp_q;
        if (frame_end) begin
            pend_v_d = 1'b0;
            if (load) begin
                disp_d = bcd_in;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
        end
    end

    always_comb begin
        cur_bcd   = '0;
        digit_hot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_bcd      = disp_q[k*BCD_W +: BCD_W];
                digit_hot[k] = 1'b1;
            end
        end

        // Walk from the top digit down; a digit is a leading zero while
        // it and everything above it are zero. Digit 0 is never tested.
        zero_run = 1'b1;
        lz_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (disp_q[k*BCD_W +: BCD_W] == '0);
            if ((idx_q == IDX_W'(k)) && zero_run) begin
                lz_blank = 1'b1;
            end
        end

        phase = (cnt_q < CNT_ON) ? PH_BLANK : PH_ON;
        show  = (phase == PH_ON) && !(lzb_en && lz_blank);

        digit_en_d   = show ? digit_hot : '0;
        segment_d    = show ? seg_dec : '0;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            digit_en_q   <= '0;
            segment_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            digit_en_q   <= digit_en_d;
            segment_q    <= segment_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_en   = digit_en_q;
    assign segment    = segment_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with NUM_DIGITS=4, DIV=8, BLANK=2.
// A reference model tracks the position inside the frame as a single
// integer and derives digit/phase/blanking arithmetically from it.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        lzb_en;
    logic [3:0]  digit_en;
    logic [6:0]  segment;
    logic        frame_done;

    int          checks = 0;
    int          errors = 0;

    int          pos;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pend_v;
    bit          rlz;

    seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .lzb_en     (lzb_en),
        .digit_en   (digit_en),
        .segment    (segment),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    ref_seg = 7'h3F;
            4'd1:    ref_seg = 7'h06;
            4'd2:    ref_seg = 7'h5B;
            4'd3:    ref_seg = 7'h4F;
            4'd4:    ref_seg = 7'h66;
            4'd5:    ref_seg = 7'h6D;
            4'd6:    ref_seg = 7'h7D;
            4'd7:    ref_seg = 7'h07;
            4'd8:    ref_seg = 7'h7F;
            4'd9:    ref_seg = 7'h6F;
            default: ref_seg = 7'h7F;
        endcase
    endfunction

    // Called at posedge+1: drives inputs for the coming edge, predicts the
    // registered outputs after that edge, then checks them.
    task automatic tick(input bit ld, input logic [15:0] val, input bit lz);
        int          idx;
        int          c;
        bit          on;
        logic [3:0]  e_den;
        logic [6:0]  e_seg;
        bit          e_fd;
        load   = ld;
        bcd_in = val;
        lzb_en = lz;
        idx    = pos / DIV;
        c      = pos % DIV;
        on     = (c >= BLANK) && !(lz && idx > 0 && ((m_disp >> (4 * idx)) == 16'h0));
        e_den  = on ? 4'(1 << idx) : 4'h0;
        e_seg  = on ? ref_seg(m_disp[4*idx +: 4]) : 7'h00;
        e_fd   = (pos == FRAME - 1);
        if (e_fd) begin
            if (ld) m_disp = val;
            else if (m_pend_v) m_disp = m_pend;
            m_pend_v = 1'b0;
        end else if (ld) begin
            m_pend   = val;
            m_pend_v = 1'b1;
        end
        pos = (pos + 1) % FRAME;
        @(posedge clk);
        #1;
        chk("digit_en", 32'(digit_en), 32'(e_den));
        chk("segment", 32'(segment), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic idle(input int n, input bit lz);
        repeat (n) tick(1'b0, 16'h0, lz);
    endtask

    task automatic goto(input int target, input bit lz);
        while (pos != target) tick(1'b0, 16'h0, lz);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_den"}, 32'(digit_en), 32'h0);
        chk({tag, "_seg"}, 32'(segment), 32'h0);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        pos      = 0;
        m_disp   = 16'h0;
        m_pend   = 16'h0;
        m_pend_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b1;
        load   = 1'b0;
        bcd_in = 16'h0;
        lzb_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_zero("rst_hold");
        release_reset();

        // First frame after reset: 2 blank, 6 on with 0x3F, then digit 1.
        idle(FRAME, 1'b0);

        // Load in slot 1, shown only from the next frame.
        goto(DIV + 3, 1'b0);
        tick(1'b1, 16'h1234, 1'b0);
        goto(0, 1'b0);
        idle(FRAME, 1'b0);

        // Leading-zero blanking, then an all-zero word.
        goto(5, 1'b1);
        tick(1'b1, 16'h0070, 1'b1);
        goto(0, 1'b1);
        idle(FRAME, 1'b1);
        tick(1'b1, 16'h0000, 1'b1);
        goto(0, 1'b1);
        idle(FRAME, 1'b1);

        // Non-BCD codes light all segments.
        tick(1'b1, 16'hA5F0, 1'b0);
        goto(0, 1'b0);
        idle(FRAME, 1'b0);

        // Last load wins; load on the boundary goes straight to display.
        tick(1'b1, 16'h1111, 1'b0);
        idle(5, 1'b0);
        tick(1'b1, 16'h2222, 1'b0);
        goto(0, 1'b0);
        idle(FRAME, 1'b0);
        goto(FRAME - 1, 1'b0);
        tick(1'b1, 16'h5555, 1'b0);
        idle(FRAME, 1'b0);

        // Reset mid-ON of digit 2 with a load still pending.
        tick(1'b1, 16'h9876, 1'b0);
        goto(0, 1'b0);
        goto(DIV, 1'b0);
        tick(1'b1, 16'h8888, 1'b0);
        goto(2 * DIV + 4, 1'b0);
        chk("pre_rst_den", 32'(digit_en), 32'h4);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(posedge clk); #1;
        chk_zero("rst_mid_hold");
        release_reset();
        idle(2 * FRAME, 1'b0);

        // Random loads (occasionally on the boundary) and lzb toggling.
        rlz = 1'b0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 31) == 0) rlz = ~rlz;
            if ($urandom_range(0, 11) == 0 || (pos == FRAME - 1 && $urandom_range(0, 2) == 0))
                tick(1'b1, 16'($urandom), rlz);
            else
                tick(1'b0, 16'h0, rlz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
